// File: rtl/adder_tree_accum_ctrl.sv
// adder_tree_accum_ctrl: sequences long reduction jobs through one shared
// external combinational adder tree. Each accepted chunk is registered onto
// the tree inputs, and on the following cycle the tree sum is sign- or
// zero-extended and added into a wrapping accumulator. The total is then
// presented on a valid/ready result port.

module adder_tree_accum_ctrl #(
    parameter  int NUM_INPUTS = 8,
    parameter  int DATAW      = 8,
    parameter  int MAX_CHUNKS = 16,
    parameter  int ACCW       = 32,
    localparam int SUMW       = DATAW + $clog2(NUM_INPUTS),
    localparam int CNTW       = $clog2(MAX_CHUNKS + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [CNTW-1:0]   num_chunks_i,
    input  logic              signed_i,
    output logic              busy_o,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATAW-1:0]  in_data_i [NUM_INPUTS],
    output logic [DATAW-1:0]  tree_data_o [NUM_INPUTS],
    output logic              tree_signed_o,
    input  logic [SUMW-1:0]   tree_sum_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ACCW-1:0]   out_sum_o,
    output logic [CNTW-1:0]   chunk_cnt_o
);

    // Reject tree shapes and accumulator widths the datapath cannot support.
    if ((NUM_INPUTS < 1) || ((NUM_INPUTS & (NUM_INPUTS - 1)) != 0)) begin : gBadLanes
        $fatal(1, "adder_tree_accum_ctrl: NUM_INPUTS must be a power of 2");
    end
    if (ACCW < SUMW) begin : gBadAccw
        $fatal(1, "adder_tree_accum_ctrl: ACCW must be at least DATAW+clog2(NUM_INPUTS)");
    end

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        RESULT
    } stateT;

    stateT            state_q;
    stateT            state_d;
    logic [CNTW-1:0]  numChunks_q;
    logic [CNTW-1:0]  chunkCnt_q;
    logic             signed_q;
    logic             stageValid_q;
    logic [DATAW-1:0] treeData_q [NUM_INPUTS];
    logic [ACCW-1:0]  acc_q;
    logic             outValid_q;
    logic [ACCW-1:0]  outSum_q;

    logic             startFire;
    logic             inFire;
    logic             outFire;
    logic             inReady;
    logic [CNTW-1:0]  clampedCount;
    logic [CNTW-1:0]  chunkCntInc;
    logic [ACCW-1:0]  sumExt;

    // Handshake qualifiers and the job length clamped to what the counter supports.
    always_comb begin
        startFire    = (state_q == IDLE) && start_i;
        inFire       = in_valid_i && inReady;
        outFire      = outValid_q && out_ready_i;
        chunkCntInc  = chunkCnt_q + CNTW'(1);
        clampedCount = (num_chunks_i > CNTW'(MAX_CHUNKS)) ? CNTW'(MAX_CHUNKS) : num_chunks_i;
    end

    // Extend the tree result to accumulator width according to the job's signedness.
    always_comb begin
        sumExt = ACCW'(tree_sum_i);
        if (signed_q) begin
            sumExt = ACCW'($signed(tree_sum_i));
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a zero-length job skips straight to the drain cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (clampedCount == '0) ? DRAIN : FEED;
                end
            end
            FEED: begin
                if (inFire && (chunkCntInc == numChunks_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = RESULT;
            end
            RESULT: begin
                if (outFire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control outputs decoded from the current state.
    always_comb begin
        busy_o  = (state_q != IDLE);
        inReady = (state_q == FEED) && (chunkCnt_q < numChunks_q);
    end

    // Job setup, chunk capture into the tree stage, and accumulation of the tree sum one cycle later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            numChunks_q  <= '0;
            chunkCnt_q   <= '0;
            signed_q     <= 1'b0;
            stageValid_q <= 1'b0;
            treeData_q   <= '{default: '0};
            acc_q        <= '0;
        end else begin
            stageValid_q <= inFire;
            if (inFire) begin
                treeData_q <= in_data_i;
                chunkCnt_q <= chunkCntInc;
            end
            if (startFire) begin
                numChunks_q <= clampedCount;
                signed_q    <= signed_i;
                chunkCnt_q  <= '0;
                acc_q       <= '0;
            end else if (stageValid_q) begin
                acc_q <= acc_q + sumExt;
            end
        end
    end

    // Result register: snapshot the total once the drain has landed, hold it until accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outValid_q <= 1'b0;
            outSum_q   <= '0;
        end else begin
            if ((state_q == RESULT) && !outValid_q) begin
                outValid_q <= 1'b1;
                outSum_q   <= acc_q;
            end else if (outFire) begin
                outValid_q <= 1'b0;
            end
        end
    end

    assign in_ready_o    = inReady;
    assign tree_data_o   = treeData_q;
    assign tree_signed_o = signed_q;
    assign out_valid_o   = outValid_q;
    assign out_sum_o     = outSum_q;
    assign chunk_cnt_o   = chunkCnt_q;

endmodule

// File: doc/adder_tree_accum_ctrl.md
Name: adder_tree_accum_ctrl

Overview:
Sequencer that shares one combinational binary adder tree (NUM_INPUTS lanes) across long reduction jobs.
- A job is a dot-product-style reduction of NUM_CHUNKS × NUM_INPUTS elements, streamed in one NUM_INPUTS-wide chunk per handshake.
- The block registers each chunk onto the tree inputs, sign- or zero-extends the tree sum, and accumulates it.
- It presents the final ACCW-bit total on a valid/ready output.
- It sits between the operand stream and the result writeback in the SWIRL datapath.

Parameters:
- NUM_INPUTS, 8, tree lane count; must be a power of 2 (elaboration $fatal otherwise).
- DATAW, 8, bits per lane element.
- MAX_CHUNKS, 16, maximum chunks per job.
- ACCW, 32, accumulator and result width; must be ≥ DATAW+$clog2(NUM_INPUTS) (elaboration $fatal otherwise).
- Derived: SUMW = DATAW+$clog2(NUM_INPUTS); CNTW = $clog2(MAX_CHUNKS+1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  job start request, accepted only in IDLE
- num_chunks_i  in  CNTW  chunks in the job, sampled with start_i
- signed_i  in  1  1 = signed job, 0 = unsigned; sampled with start_i
- busy_o  out  1  high in any state other than IDLE
- in_valid_i  in  1  chunk valid
- in_ready_o  out  1  chunk ready
- in_data_i  in  DATAW×NUM_INPUTS (unpacked array)  chunk lanes
- tree_data_o  out  DATAW×NUM_INPUTS  registered operands driven to the external adder tree
- tree_signed_o  out  1  signedness to the tree's sign_unsign_ni-style select (1 = signed)
- tree_sum_i  in  SUMW  combinational tree result for tree_data_o
- out_valid_o  out  1  result valid
- out_ready_i  in  1  result accept
- out_sum_o  out  ACCW  job total
- chunk_cnt_o  out  CNTW  chunks accepted so far in the current job

Behaviour:
- Reset (rst_i high at a clock edge), regardless of state: state=IDLE.
  - All of the following are 0: busy_o, in_ready_o, out_valid_o, out_sum_o, chunk_cnt_o, tree_data_o, tree_signed_o, accumulator, stage-valid flag.
  - A reset mid-job drops the job silently; nothing is emitted.
- States:
  - IDLE: in_ready_o=0.
    - start_i=1 latches num_chunks_i and signed_i, clears the accumulator and chunk_cnt_o.
    - Next state is FEED, or DRAIN if num_chunks_i==0.
  - FEED: in_ready_o=1 while chunk_cnt_o < latched count.
    - On in_valid_i&&in_ready_o: in_data_i is registered into tree_data_o, the stage-valid flag is set, and chunk_cnt_o increments.
    - Without a handshake, the stage-valid flag clears.
    - When the last chunk is accepted, in_ready_o drops the next cycle and the state moves to DRAIN.
  - Accumulate rule, every cycle the stage-valid flag is set:
    - acc <= acc + ext(tree_sum_i).
    - ext = sign-extend from bit SUMW-1 when the latched signed bit is 1, else zero-extend.
    - The add wraps modulo 2^ACCW; no saturation and no overflow flag.
  - DRAIN: one cycle; performs the accumulate for the final chunk, then moves to RESULT.
  - RESULT: out_valid_o=1 and out_sum_o=acc, both held stable until out_ready_i.
    - On handshake: next state IDLE, out_valid_o=0 the next cycle.
- tree_signed_o is the latched signed bit, stable for the whole job.
- tree_data_o holds its last value when no new chunk is loaded.
- Latency:
  - Last-chunk handshake at edge t → out_valid_o high after edge t+2.
  - A 0-chunk job: start at t → out_valid_o after t+2, out_sum_o=0.
- Bubbles: in_valid_i low in FEED stalls the job indefinitely with no spurious accumulation.
- Start while busy: start_i is ignored outside IDLE.
- A start in the same cycle as the RESULT handshake is ignored; the earliest new start is the following cycle in IDLE.
- Back-to-back jobs: the minimum gap is one IDLE cycle.
- num_chunks_i > MAX_CHUNKS: clamped to MAX_CHUNKS.

Test Plan:
1. Unsigned sum, NUM_INPUTS=8, DATAW=8, 2 chunks of all 0xFF, signed_i=0, no stalls → out_sum_o=4080 (0x00000FF0); out_valid_o rises two cycles after the 2nd handshake.
2. Signed sum, 3 chunks of all 0xFF (−1), signed_i=1 → tree_signed_o=1 throughout; out_sum_o=0xFFFFFFE8 (−24).
3. Stall handling: 4 chunks each summing to 10, in_valid_i low for 3 cycles between chunks 2 and 3, out_ready_i low for 5 cycles in RESULT → out_sum_o=40, held stable while stalled; chunk_cnt_o=4.
4. num_chunks_i=0 with start_i → no in_ready_o pulse; out_valid_o with out_sum_o=0 two cycles after start.
5. Wrap-around with ACCW=12, unsigned, 2 chunks summing to 2040 each → out_sum_o=4080 mod 4096=4080; a 3rd identical chunk gives 6120 mod 4096=2024.
6. rst_i asserted after chunk 1 of 3; then new unsigned job of 1 chunk summing to 5 → no output from the first job; second job returns 5; start_i pulses while busy are ignored.
